// File: rtl/rx_iq_capture_axis_if.sv
// AXI-Stream link carrying captured I/Q samples to the host DMA.
//   tdata  : captured sample word {q1,i1,q0,i0}
//   tvalid : beat valid
//   tready : sink ready
//   tlast  : last sample of a frame
// master drives tdata/tvalid/tlast, slave drives tready.
interface rx_iq_capture_axis_if #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
);
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata;
  logic                              tvalid;
  logic                              tready;
  logic                              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rx_iq_capture_axis.sv
// Triggered I/Q frame capture onto AXI-Stream.
// After arming (capture_en with a non-zero frame_len), a start_trig pulse
// starts a frame of frame_len samples taken from rf_iq whenever rf_iq_valid
// is high. Samples go through a small first-word-fall-through FIFO to the
// AXIS master; the final sample of each frame carries tlast.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   rf_iq          : packed sample {q1,i1,q0,i0}
//   rf_iq_valid    : rf_iq holds a new sample
//   capture_en     : level enable for arming
//   start_trig     : single-cycle frame start
//   one_shot       : 1 = one frame per arm, 0 = re-arm after each frame
//   frame_len      : samples per frame (0 keeps the block idle)
//   m_axis         : AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy           : not idle, or FIFO still holds data
//   overflow_cnt   : samples dropped on a full FIFO, saturating
//   frame_cnt      : frames completed on AXIS, wrapping
module rx_iq_capture_axis #(
  parameter int IQ_DATA_WIDTH          = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int FIFO_DEPTH_LOG2        = 4,
  parameter int FRAME_LEN_WIDTH        = 14
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [4*IQ_DATA_WIDTH-1:0] rf_iq,
  input  logic                       rf_iq_valid,
  input  logic                       capture_en,
  input  logic                       start_trig,
  input  logic                       one_shot,
  input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
  rx_iq_capture_axis_if.master       m_axis,
  output logic                       busy,
  output logic [15:0]                overflow_cnt,
  output logic [15:0]                frame_cnt
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int W     = C_M00_AXIS_TDATA_WIDTH;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t                     state;
  state_t                     after_frame;
  logic [W:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic [FRAME_LEN_WIDTH-1:0] len_r;
  logic [FRAME_LEN_WIDTH-1:0] smp_cnt;

  logic                       full;
  logic                       empty;
  logic                       trig_hit;
  logic                       write_req;
  logic                       push;
  logic                       drop;
  logic                       pop;
  logic                       push_last;
  logic                       frame_done;
  logic [FRAME_LEN_WIDTH-1:0] cur_len;
  logic [FRAME_LEN_WIDTH-1:0] cur_idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // The trigger cycle itself may carry the first sample; frame_len is not
  // yet latched then, so the live value is used for the last-sample test.
  assign trig_hit   = (state == ARMED) && capture_en && start_trig && (|frame_len);
  assign write_req  = rf_iq_valid && ((state == CAPTURE) || trig_hit);
  assign push       = write_req && !full;
  assign drop       = write_req && full;
  assign cur_len    = trig_hit ? frame_len : len_r;
  assign cur_idx    = trig_hit ? '0 : smp_cnt;
  assign push_last  = (cur_idx == cur_len - FRAME_LEN_WIDTH'(1));
  assign frame_done = push && push_last;
  assign pop        = m_axis.tvalid && m_axis.tready;

  always_comb begin
    after_frame = IDLE;
    if (one_shot)        after_frame = DRAIN;
    else if (capture_en) after_frame = ARMED;
  end

  // Fall-through head; gated by empty so idle outputs read as zero.
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 : mem[rd_ptr][W-1:0];
  assign m_axis.tlast  = !empty && mem[rd_ptr][W];
  assign busy          = (state != IDLE) || !empty;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, rf_iq};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Capture state machine and sample counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      len_r   <= '0;
      smp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture_en && (|frame_len)) state <= ARMED;
        end
        ARMED: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (trig_hit) begin
            len_r   <= frame_len;
            smp_cnt <= push ? FRAME_LEN_WIDTH'(1) : '0;
            state   <= frame_done ? after_frame : CAPTURE;
          end
        end
        CAPTURE: begin
          if (push)       smp_cnt <= smp_cnt + FRAME_LEN_WIDTH'(1);
          if (frame_done) state   <= after_frame;
        end
        DRAIN: begin
          if (empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      if (drop)                 overflow_cnt <= sat_inc16(overflow_cnt);
      if (pop && m_axis.tlast)  frame_cnt    <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rx_iq_capture_axis.sv
module tb_rx_iq_capture_axis;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] rf_iq = '0;
  logic        rf_iq_valid = 1'b0;
  logic        capture_en = 1'b0;
  logic        start_trig = 1'b0;
  logic        one_shot = 1'b0;
  logic [13:0] frame_len = '0;
  logic        busy;
  logic [15:0] overflow_cnt;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];

  rx_iq_capture_axis_if #(.C_M00_AXIS_TDATA_WIDTH(64)) m_axis ();

  rx_iq_capture_axis #(
    .IQ_DATA_WIDTH(16),
    .C_M00_AXIS_TDATA_WIDTH(64),
    .FIFO_DEPTH_LOG2(4),
    .FRAME_LEN_WIDTH(14)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rf_iq(rf_iq),
    .rf_iq_valid(rf_iq_valid),
    .capture_en(capture_en),
    .start_trig(start_trig),
    .one_shot(one_shot),
    .frame_len(frame_len),
    .m_axis(m_axis),
    .busy(busy),
    .overflow_cnt(overflow_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mk(input int t, input int i);
    return {16'(t), 16'(i), 16'(~i), 16'(i * 3 + 5)};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beats are sampled mid-cycle, ahead of the edge that accepts them.
  task automatic tick();
    logic [64:0] e;
    @(negedge clk);
    if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
      chk("beat_expected", 65'(exp_q.size() != 0), 65'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", {m_axis.tlast, m_axis.tdata}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    chk(tag, 65'(exp_q.size()), 65'(0));
  endtask

  initial begin
    m_axis.tready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 65'(m_axis.tvalid), 65'(0));
    chk("rst_tlast", 65'(m_axis.tlast), 65'(0));
    chk("rst_tdata", 65'(m_axis.tdata), 65'(0));
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_ovf", 65'(overflow_cnt), 65'(0));
    chk("rst_frames", 65'(frame_cnt), 65'(0));
    rstn = 1'b1;
    tick();

    // One-shot frame of 8, valid every 4 cycles
    m_axis.tready = 1'b1;
    one_shot = 1'b1;
    frame_len = 14'd8;
    capture_en = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      start_trig  = (k == 0);
      rf_iq_valid = (k % 4 == 0);
      rf_iq       = mk(1, k / 4);
      if (k % 4 == 0) exp_q.push_back({(k / 4) == 7, mk(1, k / 4)});
      tick();
      start_trig = 1'b0;
      capture_en = 1'b0;
    end
    rf_iq_valid = 1'b0;
    wait_drain("t1_drain", 50);
    repeat (3) tick();
    chk("t1_frames", 65'(frame_cnt), 65'(1));
    chk("t1_ovf", 65'(overflow_cnt), 65'(0));
    chk("t1_busy", 65'(busy), 65'(0));

    // Frame of 32 with sink stalled: 16 buffered, 24 dropped
    m_axis.tready = 1'b0;
    frame_len = 14'd32;
    capture_en = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      start_trig  = (k == 0);
      rf_iq_valid = 1'b1;
      rf_iq       = mk(2, k);
      if (k < 16) exp_q.push_back({1'b0, mk(2, k)});
      tick();
      start_trig = 1'b0;
      capture_en = 1'b0;
    end
    chk("t2_ovf_stall", 65'(overflow_cnt), 65'(24));
    chk("t2_hold_data", {m_axis.tlast, m_axis.tdata}, {1'b0, mk(2, 0)});
    // Pop and push in the same cycle while full: the push is still refused
    m_axis.tready = 1'b1;
    rf_iq = mk(2, 99);
    tick();
    chk("t2_ovf_full_pop", 65'(overflow_cnt), 65'(25));
    for (int k = 16; k < 32; k++) begin
      rf_iq = mk(2, k);
      exp_q.push_back({k == 31, mk(2, k)});
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      rf_iq = mk(2, 200 + k);
      tick();
    end
    rf_iq_valid = 1'b0;
    wait_drain("t2_drain", 50);
    repeat (3) tick();
    chk("t2_frames", 65'(frame_cnt), 65'(2));
    chk("t2_ovf_end", 65'(overflow_cnt), 65'(25));

    // Continuous mode, frame_len 3, re-trigger mid-frame ignored
    one_shot = 1'b0;
    frame_len = 14'd3;
    capture_en = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 3; s++) begin
        start_trig  = (s < 2);
        rf_iq_valid = 1'b1;
        rf_iq       = mk(3, f * 3 + s);
        exp_q.push_back({s == 2, mk(3, f * 3 + s)});
        tick();
      end
      start_trig  = 1'b0;
      rf_iq_valid = 1'b0;
      tick();
    end
    capture_en = 1'b0;
    wait_drain("t3_drain", 50);
    repeat (2) tick();
    chk("t3_frames", 65'(frame_cnt), 65'(5));
    chk("t3_busy", 65'(busy), 65'(0));

    // Frame length 1: trigger and sample together
    one_shot = 1'b1;
    frame_len = 14'd1;
    capture_en = 1'b1;
    tick();
    start_trig  = 1'b1;
    rf_iq_valid = 1'b1;
    rf_iq       = mk(4, 7);
    exp_q.push_back({1'b1, mk(4, 7)});
    tick();
    start_trig  = 1'b0;
    rf_iq_valid = 1'b0;
    capture_en  = 1'b0;
    chk("t4_tvalid", 65'(m_axis.tvalid), 65'(1));
    chk("t4_beat", {m_axis.tlast, m_axis.tdata}, {1'b1, mk(4, 7)});
    wait_drain("t4_drain", 20);
    repeat (3) tick();
    chk("t4_frames", 65'(frame_cnt), 65'(6));

    // Disarm from ARMED, and frame_len 0 never arms
    frame_len = 14'd5;
    capture_en = 1'b1;
    tick();
    chk("t5_armed_busy", 65'(busy), 65'(1));
    capture_en = 1'b0;
    tick();
    chk("t5_disarm_busy", 65'(busy), 65'(0));
    start_trig  = 1'b1;
    rf_iq_valid = 1'b1;
    rf_iq       = mk(5, 1);
    repeat (2) tick();
    chk("t5_no_out", 65'(m_axis.tvalid), 65'(0));
    start_trig  = 1'b0;
    rf_iq_valid = 1'b0;
    frame_len   = 14'd0;
    capture_en  = 1'b1;
    repeat (2) tick();
    start_trig  = 1'b1;
    rf_iq_valid = 1'b1;
    tick();
    start_trig  = 1'b0;
    rf_iq_valid = 1'b0;
    tick();
    chk("t5_len0_busy", 65'(busy), 65'(0));
    chk("t5_len0_tvalid", 65'(m_axis.tvalid), 65'(0));
    capture_en = 1'b0;

    // Reset mid-capture with 5 entries buffered
    m_axis.tready = 1'b0;
    frame_len = 14'd10;
    capture_en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      start_trig  = (k == 0);
      rf_iq_valid = 1'b1;
      rf_iq       = mk(6, k);
      tick();
      start_trig = 1'b0;
    end
    rf_iq_valid = 1'b0;
    capture_en  = 1'b0;
    chk("t6_pre_tvalid", 65'(m_axis.tvalid), 65'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_tvalid", 65'(m_axis.tvalid), 65'(0));
    chk("t6_rst_tdata", 65'(m_axis.tdata), 65'(0));
    chk("t6_rst_tlast", 65'(m_axis.tlast), 65'(0));
    chk("t6_rst_ovf", 65'(overflow_cnt), 65'(0));
    chk("t6_rst_frames", 65'(frame_cnt), 65'(0));
    chk("t6_rst_busy", 65'(busy), 65'(0));
    m_axis.tready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) tick();
    chk("t6_no_stale", 65'(m_axis.tvalid), 65'(0));
    chk("t6_frames_after", 65'(frame_cnt), 65'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
